// File: rtl/branch_pred_ctrl_pkg.sv
// Shared branch-type codes, predictor defaults and 2-bit counter encodings.
package branch_pred_ctrl_pkg;

    localparam int unsigned BP_ENTRIES = 16;

    // 2-bit saturating counter states
    localparam logic [1:0] CNT_SNT = 2'b00;
    localparam logic [1:0] CNT_WNT = 2'b01;
    localparam logic [1:0] CNT_WT  = 2'b10;
    localparam logic [1:0] CNT_ST  = 2'b11;

    // Branch-type encoding; every code not listed is "no branch"
    localparam logic [3:0] BR_NONE = 4'd0;
    localparam logic [3:0] BR_BEQ  = 4'd1;
    localparam logic [3:0] BR_BNE  = 4'd2;
    localparam logic [3:0] BR_BLT  = 4'd3;
    localparam logic [3:0] BR_BGE  = 4'd4;
    localparam logic [3:0] BR_BLTU = 4'd5;
    localparam logic [3:0] BR_BGEU = 4'd6;
    localparam logic [3:0] BR_JAL  = 4'd7;
    localparam logic [3:0] BR_JALR = 4'd8;

    // True for BEQ..BGEU
    function automatic logic br_is_cond(input logic [3:0] t);
        return (t >= BR_BEQ) && (t <= BR_BGEU);
    endfunction

    // True for JAL and JALR
    function automatic logic br_is_jump(input logic [3:0] t);
        return (t == BR_JAL) || (t == BR_JALR);
    endfunction

endpackage

// File: rtl/branch_pred_ctrl_sat_cnt2.sv
// Two-bit saturating up/down counter step.
module sat_cnt2 (
    input  logic [1:0] cnt,
    input  logic       taken,
    output logic [1:0] next
);

    // Move toward strongly-taken on taken, toward strongly-not-taken otherwise
    always_comb begin
        next = cnt;
        if (taken) begin
            if (cnt != 2'b11) next = cnt + 2'd1;
        end else begin
            if (cnt != 2'b00) next = cnt - 2'd1;
        end
    end

endmodule

// File: rtl/branch_pred_ctrl.sv
// Direct-mapped BTB/BHT predictor with EX-stage resolution and statistics.
module branch_pred_ctrl
    import branch_pred_ctrl_pkg::*;
#(
    parameter int unsigned ENTRIES  = BP_ENTRIES,
    parameter logic [1:0]  CNT_INIT = CNT_WNT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] if_pc,
    output logic        pred_taken,
    output logic [31:0] pred_npc,
    input  logic        ex_valid,
    input  logic [31:0] ex_pc,
    input  logic [3:0]  ex_br_type,
    input  logic [1:0]  ex_npc_sel,
    input  logic [31:0] ex_target,
    input  logic        ex_pred_taken,
    input  logic [31:0] ex_pred_npc,
    output logic        flush,
    output logic [31:0] redirect_pc,
    output logic [31:0] br_cnt,
    output logic [31:0] mispred_cnt
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int unsigned TAG_W = 32 - IDX_W - 2;

    logic             valid_q  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [31:0]      target_q [ENTRIES];
    logic [1:0]       cnt_q    [ENTRIES];

    logic [IDX_W-1:0] if_idx, ex_idx;
    logic [TAG_W-1:0] if_tag, ex_tag;
    logic             if_hit, ex_hit;
    logic             is_cond, is_jump, resolve;
    logic             actual_taken;
    logic [31:0]      actual_npc, ex_pc_inc;
    logic [1:0]       cnt_next;
    logic             unused_ok;

    // The carried-down taken bit is implied by pred_npc and not needed here
    assign unused_ok = ex_pred_taken;

    assign if_idx = if_pc[IDX_W+1:2];
    assign if_tag = if_pc[31:IDX_W+2];
    assign ex_idx = ex_pc[IDX_W+1:2];
    assign ex_tag = ex_pc[31:IDX_W+2];

    // Fetch-stage lookup reads the table state before any same-cycle update
    assign if_hit     = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    assign pred_taken = if_hit && cnt_q[if_idx][1];
    assign pred_npc   = pred_taken ? target_q[if_idx] : (if_pc + 32'd4);

    // EX-stage resolution and misprediction detection
    assign is_cond      = br_is_cond(ex_br_type);
    assign is_jump      = br_is_jump(ex_br_type);
    assign resolve      = ex_valid && (is_cond || is_jump) && !rst;
    assign actual_taken = (ex_npc_sel != 2'd0);
    assign ex_pc_inc    = ex_pc + 32'd4;
    assign actual_npc   = actual_taken ? ex_target : ex_pc_inc;
    assign flush        = resolve && (ex_pred_npc != actual_npc);
    assign redirect_pc  = resolve ? actual_npc : ex_pc_inc;
    assign ex_hit       = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

    sat_cnt2 u_sat_cnt2 (
        .cnt   (cnt_q[ex_idx]),
        .taken (actual_taken),
        .next  (cnt_next)
    );

    // Table training and statistics on each resolve event
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(ENTRIES); i++) begin
                valid_q[i] <= 1'b0;
                cnt_q[i]   <= CNT_INIT;
            end
            br_cnt      <= 32'd0;
            mispred_cnt <= 32'd0;
        end else if (resolve) begin
            br_cnt <= br_cnt + 32'd1;
            if (flush) mispred_cnt <= mispred_cnt + 32'd1;
            if (is_jump) begin
                valid_q[ex_idx]  <= 1'b1;
                tag_q[ex_idx]    <= ex_tag;
                target_q[ex_idx] <= ex_target;
                cnt_q[ex_idx]    <= CNT_ST;
            end else if (ex_hit) begin
                cnt_q[ex_idx] <= cnt_next;
                if (actual_taken) target_q[ex_idx] <= ex_target;
            end else if (actual_taken) begin
                valid_q[ex_idx]  <= 1'b1;
                tag_q[ex_idx]    <= ex_tag;
                target_q[ex_idx] <= ex_target;
                cnt_q[ex_idx]    <= CNT_WT;
            end
        end
    end

endmodule

// File: tb/tb_branch_pred_ctrl.sv
// Randomized and directed bench for branch_pred_ctrl against a table model.
module tb_branch_pred_ctrl;
    import branch_pred_ctrl_pkg::*;

    localparam int unsigned ENT = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_npc;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [3:0]  ex_br_type;
    logic [1:0]  ex_npc_sel;
    logic [31:0] ex_target;
    logic        ex_pred_taken;
    logic [31:0] ex_pred_npc;
    logic        flush;
    logic [31:0] redirect_pc;
    logic [31:0] br_cnt;
    logic [31:0] mispred_cnt;

    branch_pred_ctrl #(.ENTRIES(ENT), .CNT_INIT(2'b01)) dut (
        .clk           (clk),
        .rst           (rst),
        .if_pc         (if_pc),
        .pred_taken    (pred_taken),
        .pred_npc      (pred_npc),
        .ex_valid      (ex_valid),
        .ex_pc         (ex_pc),
        .ex_br_type    (ex_br_type),
        .ex_npc_sel    (ex_npc_sel),
        .ex_target     (ex_target),
        .ex_pred_taken (ex_pred_taken),
        .ex_pred_npc   (ex_pred_npc),
        .flush         (flush),
        .redirect_pc   (redirect_pc),
        .br_cnt        (br_cnt),
        .mispred_cnt   (mispred_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: one record per slot, counter kept as a plain integer 0..3
    bit          m_v   [ENT];
    logic [31:0] m_tag [ENT];
    logic [31:0] m_tgt [ENT];
    int          m_cnt [ENT];
    logic [31:0] m_br, m_mis;

    int n_tests = 0;
    int n_fail  = 0;

    logic        obs_pt, obs_fl;
    logic [31:0] obs_npc, obs_rd;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic void m_reset();
        for (int i = 0; i < int'(ENT); i++) begin
            m_v[i]   = 1'b0;
            m_cnt[i] = 1;
        end
        m_br  = 0;
        m_mis = 0;
    endfunction

    function automatic int unsigned slot_of(input logic [31:0] pc);
        return (pc / 4) % ENT;
    endfunction

    function automatic logic [31:0] tag_of(input logic [31:0] pc);
        return pc / (4 * ENT);
    endfunction

    function automatic void m_lookup(input logic [31:0] pc, output logic t, output logic [31:0] npc);
        int unsigned s;
        s   = slot_of(pc);
        t   = m_v[s] && (m_tag[s] == tag_of(pc)) && (m_cnt[s] >= 2);
        npc = t ? m_tgt[s] : pc + 4;
    endfunction

    // One cycle: drive, check combinational and registered outputs, then train the model
    task automatic run_cycle(input logic r, input logic [31:0] ipc, input logic v,
                             input logic [31:0] epc, input logic [3:0] bt, input logic [1:0] sel,
                             input logic [31:0] tgt, input logic [31:0] pnpc);
        logic        e_pt, taken, e_fl, is_c, is_j, res;
        logic [31:0] e_npc, a_npc, e_rd;
        int unsigned s;
        rst = r; if_pc = ipc; ex_valid = v; ex_pc = epc; ex_br_type = bt;
        ex_npc_sel = sel; ex_target = tgt; ex_pred_npc = pnpc;
        m_lookup(epc, ex_pred_taken, e_npc);
        @(negedge clk);
        m_lookup(ipc, e_pt, e_npc);
        is_c  = (bt >= 1) && (bt <= 6);
        is_j  = (bt == 7) || (bt == 8);
        res   = !r && v && (is_c || is_j);
        taken = (sel != 0);
        a_npc = taken ? tgt : epc + 4;
        e_fl  = res && (pnpc != a_npc);
        e_rd  = res ? a_npc : epc + 4;
        obs_pt = pred_taken; obs_npc = pred_npc; obs_fl = flush; obs_rd = redirect_pc;
        check_eq("pred_taken", 32'(pred_taken), 32'(e_pt));
        check_eq("pred_npc", pred_npc, e_npc);
        check_eq("flush", 32'(flush), 32'(e_fl));
        check_eq("redirect_pc", redirect_pc, e_rd);
        check_eq("br_cnt", br_cnt, m_br);
        check_eq("mispred_cnt", mispred_cnt, m_mis);
        @(posedge clk);
        #1;
        s = slot_of(epc);
        if (r) begin
            m_reset();
        end else if (res) begin
            m_br++;
            if (e_fl) m_mis++;
            if (is_j) begin
                m_v[s] = 1'b1; m_tag[s] = tag_of(epc); m_tgt[s] = tgt; m_cnt[s] = 3;
            end else if (m_v[s] && m_tag[s] == tag_of(epc)) begin
                m_cnt[s] = taken ? ((m_cnt[s] == 3) ? 3 : m_cnt[s] + 1)
                                 : ((m_cnt[s] == 0) ? 0 : m_cnt[s] - 1);
                if (taken) m_tgt[s] = tgt;
            end else if (taken) begin
                m_v[s] = 1'b1; m_tag[s] = tag_of(epc); m_tgt[s] = tgt; m_cnt[s] = 2;
            end
        end
    endtask

    task automatic probe(input logic [31:0] ipc);
        run_cycle(1'b0, ipc, 1'b0, 32'h0, BR_NONE, 2'd0, 32'h0, 32'h0);
    endtask

    initial begin
        logic [31:0] ipc, epc, tgt, pnpc, mp;
        logic [3:0]  bt;
        logic [1:0]  sel;
        logic        v, r, mt;

        rst = 1'b1; if_pc = 32'h0; ex_valid = 1'b0; ex_pc = 32'h0; ex_br_type = BR_NONE;
        ex_npc_sel = 2'd0; ex_target = 32'h0; ex_pred_taken = 1'b0; ex_pred_npc = 32'h0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;

        // Lookup right after reset
        probe(32'h1000);
        check_eq("rst_pred_taken", 32'(obs_pt), 32'd0);
        check_eq("rst_pred_npc", obs_npc, 32'h1004);

        // Taken BEQ miss; same-cycle lookup sees the old table
        run_cycle(1'b0, 32'h1000, 1'b1, 32'h1000, BR_BEQ, 2'd1, 32'h1040, 32'h1004);
        check_eq("beq_flush", 32'(obs_fl), 32'd1);
        check_eq("beq_redirect", obs_rd, 32'h1040);
        check_eq("no_bypass", 32'(obs_pt), 32'd0);
        probe(32'h1000);
        check_eq("alloc_pred_taken", 32'(obs_pt), 32'd1);
        check_eq("alloc_pred_npc", obs_npc, 32'h1040);

        // Same slot, different tag
        probe(32'h1040);
        check_eq("alias_pred_taken", 32'(obs_pt), 32'd0);

        // Saturation: up to 11, down to 00, stay at 00
        repeat (3) run_cycle(1'b0, 32'h1000, 1'b1, 32'h1000, BR_BEQ, 2'd1, 32'h1040, 32'h1040);
        repeat (4) run_cycle(1'b0, 32'h1000, 1'b1, 32'h1000, BR_BEQ, 2'd0, 32'h1040, 32'h1004);
        probe(32'h1000);
        check_eq("sat_low_pred", 32'(obs_pt), 32'd0);
        run_cycle(1'b0, 32'h1000, 1'b1, 32'h1000, BR_BEQ, 2'd1, 32'h1040, 32'h1004);
        probe(32'h1000);
        check_eq("sat_low_then_taken", 32'(obs_pt), 32'd0);

        // JALR target change
        run_cycle(1'b0, 32'h2000, 1'b1, 32'h2000, BR_JALR, 2'd2, 32'h3000, 32'h2004);
        probe(32'h2000);
        check_eq("jalr_npc1", obs_npc, 32'h3000);
        run_cycle(1'b0, 32'h2000, 1'b1, 32'h2000, BR_JALR, 2'd2, 32'h3100, 32'h3000);
        check_eq("jalr_flush", 32'(obs_fl), 32'd1);
        check_eq("jalr_redirect", obs_rd, 32'h3100);
        probe(32'h2000);
        check_eq("jalr_npc2", obs_npc, 32'h3100);

        // Statistics, then reset with a mispredicting branch in EX
        run_cycle(1'b1, 32'h0, 1'b0, 32'h0, BR_NONE, 2'd0, 32'h0, 32'h0);
        for (int i = 0; i < 10; i++)
            run_cycle(1'b0, 32'h4000, 1'b1, 32'h4000, BR_BNE, 2'd0, 32'h4080,
                      (i < 3) ? 32'hdead0000 : 32'h4004);
        probe(32'h4000);
        check_eq("stat_br", br_cnt, 32'd10);
        check_eq("stat_mis", mispred_cnt, 32'd3);
        run_cycle(1'b1, 32'h4000, 1'b1, 32'h4000, BR_BEQ, 2'd1, 32'h4080, 32'h4004);
        check_eq("rst_flush", 32'(obs_fl), 32'd0);
        probe(32'h4000);
        check_eq("rst_br", br_cnt, 32'd0);
        check_eq("rst_mis", mispred_cnt, 32'd0);

        // Random traffic over a small PC pool so slots, tags and ex/if collisions recur
        for (int n = 0; n < 2000; n++) begin
            epc = 32'h1000 + 4 * $urandom_range(0, 47);
            ipc = ($urandom_range(0, 3) == 0) ? epc : 32'h1000 + 4 * $urandom_range(0, 47);
            bt  = 4'($urandom_range(0, 15));
            v   = ($urandom_range(0, 9) != 0);
            r   = ($urandom_range(0, 199) == 0);
            tgt = 32'h8000 + 4 * $urandom_range(0, 7);
            if (bt == BR_JAL)       sel = 2'd1;
            else if (bt == BR_JALR) sel = 2'd2;
            else                    sel = 2'($urandom_range(0, 1));
            m_lookup(epc, mt, mp);
            case ($urandom_range(0, 3))
                0:       pnpc = epc + 4;
                1:       pnpc = tgt;
                default: pnpc = mp;
            endcase
            run_cycle(r, ipc, v, epc, bt, sel, tgt, pnpc);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
